// File: rtl/rf_multiport.sv
// Multi-port register file: two combinational read ports, two write ports
// (port 2 wins on collision), optional zero register and write-to-read bypass,
// plus a one-entry-per-cycle hardware clear sequencer.
`timescale 1ns/1ps
module rf_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr1_en, wr2_en;

  // Effective commits: only in IDLE, port 1 loses a same-address collision.
  always_comb begin
    wr2_en = (state_q == IDLE) && we2 && !(ZERO_REG && wa2 == '0);
    wr1_en = (state_q == IDLE) && we1 && !(we2 && wa1 == wa2)
             && !(ZERO_REG && wa1 == '0);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == SWEEP);
    clr_done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (state_q == SWEEP) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wr2_en) mem_q[wa2] <= wd2;
      if (wr1_en) mem_q[wa1] <= wd1;
    end
  end

  // Later assignments take precedence: port 2 over port 1, zero/reset over all.
  always_comb begin
    rd1 = mem_q[ra1];
    if (BYPASS && wr1_en && wa1 == ra1) rd1 = wd1;
    if (BYPASS && wr2_en && wa2 == ra1) rd1 = wd2;
    if ((ZERO_REG && ra1 == '0) || !rst_n) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (BYPASS && wr1_en && wa1 == ra2) rd2 = wd1;
    if (BYPASS && wr2_en && wa2 == ra2) rd2 = wd2;
    if ((ZERO_REG && ra2 == '0) || !rst_n) rd2 = '0;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: one bypassing and one non-bypassing
// instance share stimulus and are compared against an array-based model.
`timescale 1ns/1ps
module tb_rf_multiport;
  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa1 = '0, wa2 = '0;
  logic [31:0] wd1 = '0, wd2 = '0;
  logic        we1 = 1'b0, we2 = 1'b0, clr_req = 1'b0;
  logic [31:0] rd1_b, rd2_b, rd1_nb, rd2_nb;
  logic        busy_b, done_b, busy_nb, done_nb;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stored contents plus cycles elapsed since a clear was accepted
  // (0 = idle, 1..DEPTH = sweeping, DEPTH+1 = done).
  logic [31:0] m_mem [DEPTH];
  int          lock = 0;

  always #5 clk = ~clk;

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
    .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb));

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == '0) return '0;
    if (byp && lock == 0) begin
      if (we2 && wa2 == ra) return wd2;
      if (we1 && wa1 == ra) return wd1;
    end
    return m_mem[ra];
  endfunction

  function automatic bit exp_busy();
    return (lock >= 1) && (lock <= int'(DEPTH));
  endfunction

  function automatic bit exp_done();
    return lock == int'(DEPTH) + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    lock = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (lock == 0) begin
      if (we2 && wa2 != '0) m_mem[wa2] = wd2;
      if (we1 && wa1 != '0 && !(we2 && wa1 == wa2)) m_mem[wa1] = wd1;
      if (clr_req) lock = 1;
    end else if (lock <= int'(DEPTH)) begin
      m_mem[5'(lock - 1)] = '0;
      lock++;
    end else begin
      lock = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we1 = 1'b0; we2 = 1'b0; clr_req = 1'b0;
  endtask

  task automatic rand_inputs();
    we1 = 1'($urandom_range(0, 1));
    we2 = 1'($urandom_range(0, 1));
    wa1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    wa2 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
    wd1 = $urandom;
    wd2 = $urandom;
    ra1 = ($urandom_range(0, 1) == 1) ? wa1 : 5'($urandom_range(0, 31));
    ra2 = ($urandom_range(0, 1) == 1) ? wa2 : 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    ra1 = 5'd5; ra2 = 5'd31;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hA5A5_A5A5;
    we2 = 1'b1; wa2 = 5'd31; wd2 = 32'h5A5A_5A5A;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (rd1_b !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h expected %h", rd1_b, 32'h0); end
    n_checks++; if (rd2_b !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h expected %h", rd2_b, 32'h0); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_b); end
    @(posedge clk); #3;
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++; if (rd1_b !== 32'h0 || rd1_nb !== 32'h0) begin n_fail++; $display("FAIL post_reset_rd1: got %h/%h expected 0", rd1_b, rd1_nb); end
    n_checks++; if (rd2_b !== 32'h0 || rd2_nb !== 32'h0) begin n_fail++; $display("FAIL post_reset_rd2: got %h/%h expected 0", rd2_b, rd2_nb); end
    n_checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin n_fail++; $display("FAIL post_reset_fsm: got busy %b done %b expected 0 0", busy_b, done_b); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hDEAD_BEEF; ra1 = 5'd3;
    #1;
    n_checks++; if (rd1_b !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd1_b, 32'hDEAD_BEEF); end
    n_checks++; if (rd1_nb !== 32'h0) begin n_fail++; $display("FAIL nobypass_before_edge: got %h expected %h", rd1_nb, 32'h0); end
    tick();
    we1 = 1'b0;
    #1;
    n_checks++; if (rd1_nb !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL nobypass_after_edge: got %h expected %h", rd1_nb, 32'hDEAD_BEEF); end
    n_checks++; if (rd1_b !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_stored: got %h expected %h", rd1_b, 32'hDEAD_BEEF); end
  endtask

  task automatic test_collision();
    idle_inputs();
    we1 = 1'b1; we2 = 1'b1; wa1 = 5'd7; wa2 = 5'd7;
    wd1 = 32'h1111; wd2 = 32'h2222; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    n_checks++; if (rd1_b !== 32'h2222) begin n_fail++; $display("FAIL collide_bypass_rd1: got %h expected %h", rd1_b, 32'h2222); end
    n_checks++; if (rd2_b !== 32'h2222) begin n_fail++; $display("FAIL collide_bypass_rd2: got %h expected %h", rd2_b, 32'h2222); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (rd1_nb !== 32'h2222) begin n_fail++; $display("FAIL collide_stored: got %h expected %h", rd1_nb, 32'h2222); end
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF; ra1 = 5'd0;
    #1;
    n_checks++; if (rd1_b !== 32'h0) begin n_fail++; $display("FAIL zero_reg_bypass: got %h expected %h", rd1_b, 32'h0); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (rd1_nb !== 32'h0 || rd1_b !== 32'h0) begin n_fail++; $display("FAIL zero_reg_stored: got %h/%h expected 0", rd1_b, rd1_nb); end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rand_inputs();
      #1;
      n_checks++; if (rd1_b !== exp_rd(ra1, 1'b1)) begin n_fail++; $display("FAIL rand_rd1_byp ra=%0d: got %h expected %h", ra1, rd1_b, exp_rd(ra1, 1'b1)); end
      n_checks++; if (rd2_b !== exp_rd(ra2, 1'b1)) begin n_fail++; $display("FAIL rand_rd2_byp ra=%0d: got %h expected %h", ra2, rd2_b, exp_rd(ra2, 1'b1)); end
      n_checks++; if (rd1_nb !== exp_rd(ra1, 1'b0)) begin n_fail++; $display("FAIL rand_rd1_nobyp ra=%0d: got %h expected %h", ra1, rd1_nb, exp_rd(ra1, 1'b0)); end
      n_checks++; if (rd2_nb !== exp_rd(ra2, 1'b0)) begin n_fail++; $display("FAIL rand_rd2_nobyp ra=%0d: got %h expected %h", ra2, rd2_nb, exp_rd(ra2, 1'b0)); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    int busy_cycles = 0;
    int done_cycles = 0;
    idle_inputs();
    for (int a = 1; a < int'(DEPTH); a++) begin
      we1 = 1'b1; wa1 = 5'(a); wd1 = 32'(a);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    #1;
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_before_accept: got %b expected 0", busy_b); end
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= int'(DEPTH) + 1; c++) begin
      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hBAD0_0009;
      we2 = 1'b1; wa2 = 5'(c); wd2 = $urandom;
      ra1 = 5'(c - 1); ra2 = 5'd9;
      #1;
      n_checks++; if (busy_b !== exp_busy() || done_b !== exp_done()) begin n_fail++; $display("FAIL sweep_fsm c=%0d: got busy %b done %b expected %b %b", c, busy_b, done_b, exp_busy(), exp_done()); end
      n_checks++; if (rd1_b !== exp_rd(ra1, 1'b1)) begin n_fail++; $display("FAIL sweep_rd1 c=%0d: got %h expected %h", c, rd1_b, exp_rd(ra1, 1'b1)); end
      n_checks++; if (rd2_b !== exp_rd(ra2, 1'b1)) begin n_fail++; $display("FAIL sweep_rd9 c=%0d: got %h expected %h", c, rd2_b, exp_rd(ra2, 1'b1)); end
      if (busy_b === 1'b1) busy_cycles++;
      if (done_b === 1'b1) begin
        done_cycles++;
        n_checks++; if (c != int'(DEPTH) + 1) begin n_fail++; $display("FAIL sweep_done_cycle: got %0d expected %0d", c, DEPTH + 1); end
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++; if (busy_cycles != int'(DEPTH)) begin n_fail++; $display("FAIL sweep_busy_len: got %0d expected %0d", busy_cycles, DEPTH); end
    n_checks++; if (done_cycles != 1) begin n_fail++; $display("FAIL sweep_done_count: got %0d expected 1", done_cycles); end
    n_checks++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL sweep_back_idle: got busy %b done %b expected 0 0", busy_b, done_b); end
    for (int a = 0; a < int'(DEPTH); a++) begin
      ra1 = 5'(a); ra2 = 5'(a);
      #1;
      n_checks++; if (rd1_b !== 32'h0 || rd2_nb !== 32'h0) begin n_fail++; $display("FAIL sweep_cleared a=%0d: got %h/%h expected 0", a, rd1_b, rd2_nb); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] wval;
    idle_inputs();
    for (int a = 1; a < int'(DEPTH); a++) begin
      we1 = 1'b1; wa1 = 5'(a); wd1 = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (busy_b !== 1'b0 || busy_nb !== 1'b0) begin n_fail++; $display("FAIL midsweep_busy_async: got %b/%b expected 0", busy_b, busy_nb); end
    n_checks++; if (done_b !== 1'b0 || done_nb !== 1'b0) begin n_fail++; $display("FAIL midsweep_done_async: got %b/%b expected 0", done_b, done_nb); end
    @(posedge clk); #1;
    n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL midsweep_no_done: got %b expected 0", done_b); end
    #2;
    rst_n = 1'b1;
    wval = $urandom;
    we1 = 1'b1; wa1 = 5'd4; wd1 = wval; ra1 = 5'd4;
    #1;
    n_checks++; if (rd1_b !== wval) begin n_fail++; $display("FAIL midsweep_write_bypass: got %h expected %h", rd1_b, wval); end
    tick();
    idle_inputs();
    for (int a = 0; a < int'(DEPTH); a++) begin
      ra1 = 5'(a);
      #1;
      n_checks++; if (rd1_nb !== ((a == 4) ? wval : 32'h0)) begin n_fail++; $display("FAIL midsweep_contents a=%0d: got %h expected %h", a, rd1_nb, (a == 4) ? wval : 32'h0); end
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int guard = 0;
    clr_req = 1'b1;
    for (int c = 0; c < 70; c++) begin
      rand_inputs();
      #1;
      n_checks++; if (busy_b !== exp_busy() || done_b !== exp_done()) begin n_fail++; $display("FAIL b2b_fsm c=%0d: got busy %b done %b expected %b %b", c, busy_b, done_b, exp_busy(), exp_done()); end
      n_checks++; if (rd1_b !== exp_rd(ra1, 1'b1)) begin n_fail++; $display("FAIL b2b_rd1 c=%0d: got %h expected %h", c, rd1_b, exp_rd(ra1, 1'b1)); end
      if (done_b === 1'b1) done_at.push_back(c);
      tick();
    end
    clr_req = 1'b0;
    while (lock != 0 && guard < 40) begin
      rand_inputs();
      #1;
      n_checks++; if (busy_b !== exp_busy() || done_b !== exp_done()) begin n_fail++; $display("FAIL b2b_drain_fsm: got busy %b done %b expected %b %b", busy_b, done_b, exp_busy(), exp_done()); end
      tick();
      guard++;
    end
    idle_inputs();
    n_checks++; if (done_at.size() != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_at.size()); end
    else begin
      n_checks++; if (done_at[1] - done_at[0] != int'(DEPTH) + 2) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected %0d", done_at[1] - done_at[0], DEPTH + 2); end
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      ra2 = 5'(a);
      #1;
      n_checks++; if (rd2_nb !== exp_rd(ra2, 1'b0) || rd2_b !== exp_rd(ra2, 1'b1)) begin n_fail++; $display("FAIL b2b_contents a=%0d: got %h/%h expected %h", a, rd2_b, rd2_nb, exp_rd(ra2, 1'b0)); end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    test_reset();
    test_bypass();
    test_collision();
    test_random(300);
    test_sweep();
    test_random(50);
    test_reset_mid_sweep();
    test_back_to_back();
    test_random(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
